// File: rtl/enc_frame_arbiter.sv
// ---------------------------------------------------------------------------
// enc_frame_arbiter
//
// Shares one 8b/10b encoder + CRC framing datapath among NREQ byte-stream
// requesters. One requester owns each frame; ownership rotates round-robin.
// The arbiter drives the encoder input stream: K28.5 SOF, payload bytes,
// K28.5 EOF. After each EOF it idles for GAP_CYCLES so the encoder can emit
// its trailer (K23.7, CRC, closing K28.5) without interference.
//
// Optional feature macro: ENC_ARB_TIMEOUT_EN
//   Defined     : a stalled frame (no transfer for TIMEOUT cycles) is closed
//                 with an EOF and an 'aborted' pulse.
//   Not defined : the frame waits for its owner indefinitely; 'aborted' is 0.
//
// Ports
//   clk        in   1        clock, posedge
//   reset      in   1        synchronous, active-high
//   req_valid  in   NREQ     per-channel payload byte valid
//   req_data   in   NREQ*8   per-channel byte, channel i at [8*i+7:8*i]
//   req_last   in   NREQ     per-channel end-of-frame marker
//   req_ready  out  NREQ     per-channel accept (combinational)
//   grant      out  NREQ     one-hot frame owner, 0 when idle
//   enc_pushin out  1        encoder input strobe
//   enc_startin out 1        encoder frame-active
//   enc_datain out  9        {ctrl, byte}; 9'h1BC = K28.5
//   truncated  out  1        pulse with an EOF forced by MAX_LEN
//   aborted    out  1        pulse with an EOF forced by timeout
//   dbg_state  out  3        current FSM state, for observation only
//
// Handshake: a payload byte moves from channel i in any cycle where
// req_valid[i] & req_ready[i] is high at the rising clock edge. req_ready is
// high only for the frame owner while the FSM is in DATA; a requester must
// hold data/last stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module enc_frame_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 6,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              enc_pushin,
  output logic              enc_startin,
  output logic [8:0]        enc_datain,
  output logic              truncated,
  output logic              aborted,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOF  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_EOF  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [8:0] K28_5 = 9'h1BC;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             push_q, push_d;
  logic             start_q, start_d;
  logic [8:0]       data_q, data_d;
  logic             trunc_q, trunc_d;
  logic             trunc_pend_q, trunc_pend_d;
  logic             abort_q, abort_d;

`ifdef ENC_ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall_q, stall_d;
  logic            abort_pend_q, abort_pend_d;
`endif

  // ------------------------------------------------------------------------
  // Round-robin pick: first valid channel strictly after rr_q, wrapping.
  // rr_q itself is examined last so the previous owner has lowest priority.
  // ------------------------------------------------------------------------
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_oh;
  logic [PTR_W:0]   cand_sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_sum = {1'b0, rr_q} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(NREQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NREQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    if (pick_found) begin
      pick_oh[pick_idx] = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Owner view. rr_q always holds the current owner's index while a frame is
  // in progress, so it doubles as the payload mux select.
  // ------------------------------------------------------------------------
  logic       in_data;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;
  logic       xfer;
  logic       at_cap;

  assign in_data   = (state_q == S_DATA);
  assign own_valid = req_valid[rr_q];
  assign own_last  = req_last[rr_q];
  assign own_data  = req_data[{rr_q, 3'b000} +: 8];
  assign xfer      = in_data & own_valid;
  assign at_cap    = (cnt_q == CNT_W'(MAX_LEN - 1));

  assign req_ready = in_data ? grant_q : '0;

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    push_d       = push_q;
    start_d      = start_q;
    data_d       = data_q;
    trunc_d      = 1'b0;
    trunc_pend_d = trunc_pend_q;
    abort_d      = 1'b0;
`ifdef ENC_ARB_TIMEOUT_EN
    stall_d      = stall_q;
    abort_pend_d = abort_pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        push_d  = 1'b0;
        start_d = 1'b0;
        if (pick_found) begin
          grant_d = pick_oh;
          rr_d    = pick_idx;
          state_d = S_SOF;
        end
      end

      S_SOF: begin
        push_d       = 1'b1;
        start_d      = 1'b1;
        data_d       = K28_5;
        cnt_d        = '0;
        trunc_pend_d = 1'b0;
`ifdef ENC_ARB_TIMEOUT_EN
        stall_d      = '0;
        abort_pend_d = 1'b0;
`endif
        state_d      = S_DATA;
      end

      S_DATA: begin
        start_d = 1'b1;
        push_d  = xfer;
        if (xfer) begin
          // ctrl bit forced low: payload can never alias a K character.
          data_d = {1'b0, own_data};
          cnt_d  = cnt_q + CNT_W'(1);
          if (own_last || at_cap) begin
            state_d      = S_EOF;
            // A natural end on the very byte that hits the cap is not a
            // truncation; only a cap-forced end is flagged.
            trunc_pend_d = at_cap & ~own_last;
          end
        end
`ifdef ENC_ARB_TIMEOUT_EN
        if (xfer) begin
          stall_d = '0;
        end else if (stall_q == ST_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th consecutive idle cycle: close the frame.
          state_d      = S_EOF;
          abort_pend_d = 1'b1;
        end else begin
          stall_d = stall_q + ST_W'(1);
        end
`endif
      end

      S_EOF: begin
        push_d  = 1'b1;
        start_d = 1'b1;
        data_d  = K28_5;
        trunc_d = trunc_pend_q;
`ifdef ENC_ARB_TIMEOUT_EN
        abort_d = abort_pend_q;
`endif
        gap_d   = '0;
        state_d = S_GAP;
      end

      S_GAP: begin
        grant_d = '0;
        push_d  = 1'b0;
        start_d = 1'b0;
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        push_d  = 1'b0;
        start_d = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Registers. Reset drops any frame in flight without sending an EOF.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= PTR_W'(NREQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      push_q       <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= 9'h000;
      trunc_q      <= 1'b0;
      trunc_pend_q <= 1'b0;
      abort_q      <= 1'b0;
`ifdef ENC_ARB_TIMEOUT_EN
      stall_q      <= '0;
      abort_pend_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      push_q       <= push_d;
      start_q      <= start_d;
      data_q       <= data_d;
      trunc_q      <= trunc_d;
      trunc_pend_q <= trunc_pend_d;
      abort_q      <= abort_d;
`ifdef ENC_ARB_TIMEOUT_EN
      stall_q      <= stall_d;
      abort_pend_q <= abort_pend_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign enc_pushin  = push_q;
  assign enc_startin = start_q;
  assign enc_datain  = data_q;
  assign truncated   = trunc_q;
  assign aborted     = abort_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_enc_frame_arbiter.sv
`timescale 1ns/1ps
module tb_enc_frame_arbiter;

  localparam int NREQ       = 4;
  localparam int MAX_LEN    = 64;
  localparam int GAP_CYCLES = 6;
  localparam int TIMEOUT    = 16;
  localparam int W          = 16;   // {startin, truncated, aborted, grant[3:0], datain[8:0]}

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              enc_pushin;
  logic              enc_startin;
  logic [8:0]        enc_datain;
  logic              truncated;
  logic              aborted;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  enc_frame_arbiter #(
    .NREQ(NREQ), .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .enc_pushin(enc_pushin), .enc_startin(enc_startin), .enc_datain(enc_datain),
    .truncated(truncated), .aborted(aborted), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  typedef struct {
    int         gap;
    logic [7:0] data;
    logic       last;
  } item_t;

  item_t         ch_q[NREQ][$];
  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cycle = 0;
  bit            mon_en = 1'b0;
  int            stall_seen = 0;
  bit            in_frame = 1'b0;
  int            last_eof = -100;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  initial begin : driver
    logic [NREQ-1:0] xfer;
    int              gap_cnt[NREQ];
    bit              gap_loaded[NREQ];
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int c = 0; c < NREQ; c++) begin
      gap_cnt[c]    = 0;
      gap_loaded[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < NREQ; c++) begin
        if (reset) begin
          ch_q[c].delete();
          gap_loaded[c] = 1'b0;
        end else if (xfer[c] && ch_q[c].size() > 0) begin
          void'(ch_q[c].pop_front());
          gap_loaded[c] = 1'b0;
        end
        if (ch_q[c].size() > 0) begin
          if (!gap_loaded[c]) begin
            gap_cnt[c]    = ch_q[c][0].gap;
            gap_loaded[c] = 1'b1;
          end
          if (gap_cnt[c] > 0) begin
            req_valid[c] = 1'b0;
            gap_cnt[c]--;
          end else begin
            req_valid[c]       = 1'b1;
            req_data[8*c +: 8] = ch_q[c][0].data;
            req_last[c]        = ch_q[c][0].last;
          end
        end else begin
          req_valid[c] = 1'b0;
          req_last[c]  = 1'b0;
        end
      end
    end
  end

  task automatic drv_frame(input int ch, input int n, input logic [7:0] base,
                           input logic [7:0] step, input int gap_idx, input int gap_len,
                           input bit last_at_end);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.gap  = (i == gap_idx) ? gap_len : 0;
      it.data = base + step * 8'(i);
      it.last = last_at_end && (i == n - 1);
      ch_q[ch].push_back(it);
    end
  endtask

  // ---------------- expected-value generation ----------------
  task automatic exp_sof(input int ch);
    logic [3:0] g;
    g = 4'b0001 << ch;
    exp_q.push_back({1'b1, 1'b0, 1'b0, g, 9'h1BC});
  endtask

  task automatic exp_bytes(input int ch, input int first, input int n,
                           input logic [7:0] base, input logic [7:0] step);
    logic [3:0] g;
    logic [7:0] b;
    g = 4'b0001 << ch;
    for (int i = 0; i < n; i++) begin
      b = base + step * 8'(first + i);
      exp_q.push_back({1'b1, 1'b0, 1'b0, g, 1'b0, b});
    end
  endtask

  task automatic exp_eof(input int ch, input bit trunc, input bit abrt);
    logic [3:0] g;
    g = 4'b0001 << ch;
    exp_q.push_back({1'b1, trunc, abrt, g, 9'h1BC});
  endtask

  task automatic exp_frame(input int ch, input int first, input int n,
                           input logic [7:0] base, input logic [7:0] step, input bit trunc);
    exp_sof(ch);
    exp_bytes(ch, first, n, base, step);
    exp_eof(ch, trunc, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    cycle++;
    if (reset) begin
      in_frame = 1'b0;
      last_eof = -100;
    end else if (mon_en) begin
      total++;
      if (((req_ready & ~grant) != '0) || ($countones(grant) > 1)) begin
        bad++;
        $display("FAIL grant_ready got grant=%b ready=%b exp onehot grant covering ready", grant, req_ready);
      end
      if (enc_pushin) begin
        got = {enc_startin, truncated, aborted, grant, enc_datain};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_push got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL push got=%h exp=%h", got, e);
          end
        end
        if (enc_datain == 9'h1BC) begin
          if (!in_frame) begin
            total++;
            if (cycle - last_eof < GAP_CYCLES + 2) begin
              bad++;
              $display("FAIL sof_gap got=%0d exp>=%0d", cycle - last_eof, GAP_CYCLES + 2);
            end
            in_frame = 1'b1;
          end else begin
            in_frame = 1'b0;
            last_eof = cycle;
          end
        end
      end else begin
        if (in_frame && enc_startin) stall_seen++;
        total++;
        if (truncated || aborted) begin
          bad++;
          $display("FAIL stray_pulse got=%b%b exp=00", truncated, aborted);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && (dbg_state == S_IDLE) &&
             (ch_q[0].size() == 0) && (ch_q[1].size() == 0) &&
             (ch_q[2].size() == 0) && (ch_q[3].size() == 0);
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    // Reset state, sampled while reset is held.
    chk("rst_grant",  {28'd0, grant}, 32'd0);
    chk("rst_push",   {31'd0, enc_pushin}, 32'd0);
    chk("rst_start",  {31'd0, enc_startin}, 32'd0);
    chk("rst_data",   {23'd0, enc_datain}, 32'd0);
    chk("rst_flags",  {30'd0, truncated, aborted}, 32'd0);
    chk("rst_ready",  {28'd0, req_ready}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: ch1 sends 11,22,33(last).
    drv_frame(1, 3, 8'h11, 8'h11, -1, 0, 1'b1);
    exp_frame(1, 0, 3, 8'h11, 8'h11, 1'b0);
    wait_idle("t1");

    // 2: ch0 and ch2 together from a fresh reset -> ch0 then ch2.
    pulse_reset();
    stall_seen = 0;
    drv_frame(0, 4, 8'hA0, 8'h01, -1, 0, 1'b1);
    drv_frame(2, 3, 8'hC0, 8'h01, -1, 0, 1'b1);
    exp_frame(0, 0, 4, 8'hA0, 8'h01, 1'b0);
    exp_frame(2, 0, 3, 8'hC0, 8'h01, 1'b0);
    wait_idle("t2");

    // 2b: all four valid with pointer at ch2 -> ch3, ch0, ch1, ch2.
    for (int c = 0; c < NREQ; c++) drv_frame(c, 2, 8'(8'h30 + 16 * c), 8'h01, -1, 0, 1'b1);
    exp_frame(3, 0, 2, 8'h60, 8'h01, 1'b0);
    exp_frame(0, 0, 2, 8'h30, 8'h01, 1'b0);
    exp_frame(1, 0, 2, 8'h40, 8'h01, 1'b0);
    exp_frame(2, 0, 2, 8'h50, 8'h01, 1'b0);
    wait_idle("t2b");

    // 3: ch0 streams 70 bytes -> truncated 64-byte frame, then 6-byte frame.
    drv_frame(0, 70, 8'h01, 8'h01, -1, 0, 1'b1);
    exp_frame(0, 0, 64, 8'h01, 8'h01, 1'b1);
    exp_frame(0, 64, 6, 8'h01, 8'h01, 1'b0);
    wait_idle("t3");
    chk("no_stall_so_far", stall_seen, 32'd0);

    // 4: ch2 drops valid for 3 cycles mid-frame.
    stall_seen = 0;
    drv_frame(2, 6, 8'h50, 8'h03, 3, 3, 1'b1);
    exp_frame(2, 0, 6, 8'h50, 8'h03, 1'b0);
    wait_idle("t4");
    chk("mid_frame_stall", stall_seen, 32'd3);

    // 5: ch1 sends 2 bytes then stalls.
    drv_frame(1, 2, 8'h71, 8'h11, -1, 0, 1'b0);
    exp_sof(1);
    exp_bytes(1, 0, 2, 8'h71, 8'h11);
`ifdef ENC_ARB_TIMEOUT_EN
    exp_eof(1, 1'b0, 1'b1);
    wait_idle("t5");
`else
    repeat (40) @(negedge clk);
    chk("hold_grant", {28'd0, grant}, 32'h2);
    chk("hold_start", {31'd0, enc_startin}, 32'd1);
    chk("hold_state", {29'd0, dbg_state}, {29'd0, S_DATA});
    chk("hold_exp_drained", exp_q.size(), 32'd0);
    ch_q[1].push_back('{gap: 0, data: 8'h93, last: 1'b1});
    exp_bytes(1, 2, 1, 8'h71, 8'h11);
    exp_eof(1, 1'b0, 1'b0);
    wait_idle("t5");
`endif

    // 6: reset in the DATA cycle of a 5-byte frame.
    mon_en = 1'b0;
    drv_frame(1, 5, 8'hE0, 8'h01, -1, 0, 1'b1);
    n = 0;
    while (dbg_state != S_DATA && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_data", {29'd0, dbg_state}, {29'd0, S_DATA});
    reset = 1'b1;
    @(negedge clk);
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chk("t6_push",  {31'd0, enc_pushin}, 32'd0);
    chk("t6_start", {31'd0, enc_startin}, 32'd0);
    chk("t6_data",  {23'd0, enc_datain}, 32'd0);
    chk("t6_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_eof", {31'd0, enc_pushin}, 32'd0);
    end
    mon_en = 1'b1;
    drv_frame(3, 2, 8'h0A, 8'h01, -1, 0, 1'b1);
    drv_frame(0, 1, 8'h5A, 8'h01, -1, 0, 1'b1);
    exp_frame(0, 0, 1, 8'h5A, 8'h01, 1'b0);
    exp_frame(3, 0, 2, 8'h0A, 8'h01, 1'b0);
    wait_idle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
